// File: rtl/pwm_ramp_controller_if.sv
// Ramp-request channel between the configuration side and pwm_ramp_controller.
//   tgt_valid     requester -> controller  new ramp request present
//   tgt_ready     controller -> requester  request taken when valid && ready
//   tgt_duty      requester -> controller  target duty (clamped to PERIOD by the controller)
//   tgt_step      requester -> controller  duty change per step, 0 = jump to target
//   tgt_interval  requester -> controller  PWM periods per step, 0 behaves as 1
// master: requester side, slave: controller side.
interface pwm_ramp_controller_if #(
    parameter int DUTY_W = 32,
    parameter int STEP_W = 8,
    parameter int INT_W  = 16
);
    logic              tgt_valid;
    logic              tgt_ready;
    logic [DUTY_W-1:0] tgt_duty;
    logic [STEP_W-1:0] tgt_step;
    logic [INT_W-1:0]  tgt_interval;

    modport master (
        output tgt_valid, tgt_duty, tgt_step, tgt_interval,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid, tgt_duty, tgt_step, tgt_interval,
        output tgt_ready
    );
endinterface

// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller: ramps the duty_cycle fed to pwm_generator toward a requested
// target in programmable steps. duty_cycle only ever changes on the last clock of a
// PWM period, so the generator never sees a mid-period update.
// Ports:
//   clock         system clock, rising edge
//   reset_n       asynchronous reset, active high
//   tgt           ramp request channel (slave side of pwm_ramp_controller_if)
//   abort         stop an active ramp and hold the current duty
//   duty_cycle    registered duty to pwm_generator
//   period_start  one-clock pulse on the first clock of each PWM period
//   busy          ramp in progress
//   done          one-clock pulse when duty_cycle has reached the target
//
// state | meaning
// IDLE  | waiting for a request, tgt_ready high
// RAMP  | stepping duty_cycle toward target on period boundaries
// DONE  | target reached, done pulses for one clock
module pwm_ramp_controller #(
    parameter int DUTY_W = 32,
    parameter int PERIOD = 256,
    parameter int STEP_W = 8,
    parameter int INT_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    pwm_ramp_controller_if.slave tgt,
    input  logic                 abort,
    output logic [DUTY_W-1:0]    duty_cycle,
    output logic                 period_start,
    output logic                 busy,
    output logic                 done
);
    localparam int                CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int                DIFF_W   = DUTY_W + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);
    localparam logic [INT_W-1:0]  IVL_ONE  = INT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              period_start_q, period_start_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [INT_W-1:0]  ivl_q, ivl_d;
    logic [INT_W-1:0]  icnt_q, icnt_d;

    logic              boundary;
    logic              accept;
    logic [DUTY_W-1:0] tgt_clamped;
    logic [INT_W-1:0]  ivl_req;
    logic              tgt_above;
    logic [DIFF_W-1:0] diff;
    logic [DIFF_W-1:0] step_ext;
    logic [DIFF_W-1:0] delta;
    logic [DUTY_W-1:0] duty_next;

    assign boundary = (cnt_q == CNT_LAST);
    assign accept   = (state_q == IDLE) && tgt.tgt_valid;

    assign tgt_clamped = (tgt.tgt_duty > DUTY_MAX) ? DUTY_MAX : tgt.tgt_duty;
    assign ivl_req     = (tgt.tgt_interval == '0) ? IVL_ONE : tgt.tgt_interval;

    // Distance to target is taken one bit wider than duty so the subtraction can never
    // wrap; the step is limited to that distance, which rules out overshoot.
    assign tgt_above = (tgt_q > duty_q);
    assign diff      = tgt_above ? ({1'b0, tgt_q} - {1'b0, duty_q})
                                 : ({1'b0, duty_q} - {1'b0, tgt_q});
    assign step_ext  = DIFF_W'(step_q);
    assign delta     = (step_ext < diff) ? step_ext : diff;

    always_comb begin
        duty_next = tgt_q;
        if (step_q != '0) begin
            if (tgt_above) begin
                duty_next = DUTY_W'({1'b0, duty_q} + delta);
            end else begin
                duty_next = DUTY_W'({1'b0, duty_q} - delta);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = boundary ? '0 : cnt_q + 1'b1;
        period_start_d = boundary;
        duty_d         = duty_q;
        tgt_d          = tgt_q;
        step_d         = step_q;
        ivl_d          = ivl_q;
        icnt_d         = icnt_q;

        unique case (state_q)
            IDLE: begin
                // abort is ignored here, so a request arriving alongside it is taken.
                if (accept) begin
                    tgt_d   = tgt_clamped;
                    step_d  = tgt.tgt_step;
                    ivl_d   = ivl_req;
                    icnt_d  = ivl_req;
                    state_d = (tgt_clamped == duty_q) ? DONE : RAMP;
                end
            end
            RAMP: begin
                // abort takes priority over a step landing on the same boundary.
                if (abort) begin
                    state_d = IDLE;
                end else if (boundary) begin
                    if (icnt_q > IVL_ONE) begin
                        icnt_d = icnt_q - 1'b1;
                    end else begin
                        icnt_d = ivl_q;
                        duty_d = duty_next;
                        if (duty_next == tgt_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
            duty_q         <= '0;
            tgt_q          <= '0;
            step_q         <= '0;
            ivl_q          <= IVL_ONE;
            icnt_q         <= IVL_ONE;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
            duty_q         <= duty_d;
            tgt_q          <= tgt_d;
            step_q         <= step_d;
            ivl_q          <= ivl_d;
            icnt_q         <= icnt_d;
        end
    end

    assign tgt.tgt_ready = (state_q == IDLE);
    assign busy          = (state_q == RAMP);
    assign done          = (state_q == DONE);
    assign duty_cycle    = duty_q;
    assign period_start  = period_start_q;
endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller with a duty-step scoreboard.
module tb_pwm_ramp_controller;
    localparam int DUTY_W = 32;
    localparam int PERIOD = 256;
    localparam int STEP_W = 8;
    localparam int INT_W  = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              abort;
    logic [DUTY_W-1:0] duty_cycle;
    logic              period_start;
    logic              busy;
    logic              done;

    pwm_ramp_controller_if #(.DUTY_W(DUTY_W), .STEP_W(STEP_W), .INT_W(INT_W)) tif ();

    pwm_ramp_controller #(
        .DUTY_W(DUTY_W), .PERIOD(PERIOD), .STEP_W(STEP_W), .INT_W(INT_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .tgt          (tif),
        .abort        (abort),
        .duty_cycle   (duty_cycle),
        .period_start (period_start),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] duty;
        int          bidx;   // boundary number after acceptance, 0 = not checked
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    int          total     = 0;
    int          bad       = 0;
    int          bcnt      = 0;
    int          done_cnt  = 0;
    int          cyc       = 0;
    int          last_ps   = -1;
    logic [31:0] prev_duty = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input int b);
        exp_t e;
        e.duty = d;
        e.bidx = b;
        sb_q.push_back(e);
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic request(input logic [31:0] d, input logic [7:0] s, input logic [15:0] iv);
        int n = 0;
        tif.tgt_valid    = 1'b1;
        tif.tgt_duty     = d;
        tif.tgt_step     = s;
        tif.tgt_interval = iv;
        while (tif.tgt_ready !== 1'b1 && n < 50) begin
            cycle(1);
            n++;
        end
        check("request ready", {63'd0, tif.tgt_ready}, 64'd1);
        cycle(1);
        // accepted on a boundary cycle: that boundary's pulse must not count
        bcnt = period_start ? -1 : 0;
        tif.tgt_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            cycle(1);
            n++;
        end
        check(tag, {63'd0, done}, 64'd1);
    endtask

    task automatic wait_duty(input string tag, input logic [31:0] d, input int budget);
        int n = 0;
        while (duty_cycle !== d && n < budget) begin
            cycle(1);
            n++;
        end
        check(tag, {32'd0, duty_cycle}, {32'd0, d});
    endtask

    // Scoreboard and period monitor, sampled on the falling edge.
    always @(negedge clock) begin
        cyc++;
        if (reset_n === 1'b1) begin
            prev_duty = duty_cycle;
            last_ps   = -1;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (period_start === 1'b1) begin
                bcnt++;
                if (last_ps >= 0) check("period_start spacing", 64'(cyc - last_ps), 64'(PERIOD));
                last_ps = cyc;
            end
            if (duty_cycle !== prev_duty) begin
                check("duty change at period start", {63'd0, period_start}, 64'd1);
                if (sb_q.size() == 0) begin
                    check("unexpected duty change", {32'd0, duty_cycle}, {32'd0, prev_duty});
                end else begin
                    sb_e = sb_q.pop_front();
                    check("duty step value", {32'd0, duty_cycle}, {32'd0, sb_e.duty});
                    if (sb_e.bidx > 0) check("duty step boundary", 64'(bcnt), 64'(sb_e.bidx));
                end
                prev_duty = duty_cycle;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n          = 1'b1;
        abort            = 1'b0;
        tif.tgt_valid    = 1'b0;
        tif.tgt_duty     = '0;
        tif.tgt_step     = '0;
        tif.tgt_interval = '0;

        // reset held 10 clocks
        cycle(10);
        reset_n = 1'b0;
        #1;
        check("reset duty", {32'd0, duty_cycle}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset period_start", {63'd0, period_start}, 64'd0);
        check("reset ready", {63'd0, tif.tgt_ready}, 64'd1);
        cycle(3);

        // 0 -> 255, step 64, interval 1
        push(64, 1); push(128, 2); push(192, 3); push(255, 4);
        request(255, 64, 1);
        check("ramp up busy", {63'd0, busy}, 64'd1);
        wait_done("ramp up done", 1500);
        check("ramp up final duty", {32'd0, duty_cycle}, 64'd255);
        check("ramp up done with step", {63'd0, period_start}, 64'd1);
        cycle(1);
        check("ramp up done width", {63'd0, done}, 64'd0);
        check("ramp up ready after", {63'd0, tif.tgt_ready}, 64'd1);
        check("ramp up done count", 64'(done_cnt), 64'd1);

        // 255 -> 0, step 100, interval 2
        push(155, 2); push(55, 4); push(0, 6);
        request(0, 100, 2);
        wait_done("ramp down done", 2500);
        check("ramp down final duty", {32'd0, duty_cycle}, 64'd0);
        cycle(1);
        check("ramp down busy after", {63'd0, busy}, 64'd0);
        check("ramp down done count", 64'(done_cnt), 64'd2);

        // step 0 jumps on the 3rd boundary
        push(37, 3);
        request(37, 0, 3);
        wait_done("jump done", 1200);
        check("jump final duty", {32'd0, duty_cycle}, 64'd37);
        cycle(1);
        check("jump done count", 64'(done_cnt), 64'd3);

        // target equal to current duty: done right after acceptance
        request(37, 5, 1);
        check("equal target done", {63'd0, done}, 64'd1);
        check("equal target busy", {63'd0, busy}, 64'd0);
        cycle(1);
        check("equal target done width", {63'd0, done}, 64'd0);
        check("equal target ready", {63'd0, tif.tgt_ready}, 64'd1);
        check("equal target done count", 64'(done_cnt), 64'd4);

        // reset in the middle of a ramp
        push(47, 1);
        request(100, 10, 1);
        wait_duty("pre-reset step", 47, 600);
        cycle(5);
        reset_n = 1'b1;
        #1;
        check("mid reset duty", {32'd0, duty_cycle}, 64'd0);
        check("mid reset busy", {63'd0, busy}, 64'd0);
        cycle(3);
        reset_n = 1'b0;
        cycle(3);
        check("mid reset ready", {63'd0, tif.tgt_ready}, 64'd1);
        check("mid reset no done", 64'(done_cnt), 64'd4);

        // 0 -> 200 step 10, abort on the boundary cycle after duty reaches 50
        push(10, 1); push(20, 2); push(30, 3); push(40, 4); push(50, 5);
        request(200, 10, 1);
        wait_duty("abort ramp reaches 50", 50, 1500);
        cycle(255);
        abort = 1'b1;
        cycle(1);
        abort = 1'b0;
        check("abort was on boundary", {63'd0, period_start}, 64'd1);
        check("abort duty held", {32'd0, duty_cycle}, 64'd50);
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort ready", {63'd0, tif.tgt_ready}, 64'd1);
        check("abort queue drained", 64'(sb_q.size()), 64'd0);
        cycle(300);
        check("abort duty stays", {32'd0, duty_cycle}, 64'd50);
        check("abort no done", 64'(done_cnt), 64'd4);

        // valid held through a ramp, second request clamps 300 -> 256
        tif.tgt_valid    = 1'b1;
        tif.tgt_duty     = 100;
        tif.tgt_step     = 50;
        tif.tgt_interval = 1;
        push(100, 1);
        cycle(1);
        bcnt = period_start ? -1 : 0;
        tif.tgt_duty     = 300;
        tif.tgt_step     = 100;
        tif.tgt_interval = 0;
        check("held valid busy", {63'd0, busy}, 64'd1);
        check("held valid not ready", {63'd0, tif.tgt_ready}, 64'd0);
        wait_done("held first done", 600);
        check("held first duty", {32'd0, duty_cycle}, 64'd100);
        check("held not ready at done", {63'd0, tif.tgt_ready}, 64'd0);
        cycle(1);
        check("held ready after done", {63'd0, tif.tgt_ready}, 64'd1);
        push(200, 1); push(256, 2);
        cycle(1);
        bcnt = period_start ? -1 : 0;
        tif.tgt_valid = 1'b0;
        check("clamp request busy", {63'd0, busy}, 64'd1);
        wait_done("clamp done", 1200);
        check("clamp final duty", {32'd0, duty_cycle}, 64'd256);
        cycle(1);
        check("clamp done count", 64'(done_cnt), 64'd6);
        cycle(600);
        check("clamp duty stays", {32'd0, duty_cycle}, 64'd256);
        check("clamp busy after", {63'd0, busy}, 64'd0);
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
